// File: rtl/tx_sync_inserter.sv
// TX framer: merges user data words with periodic sync words (MSB=1) that carry local blocklock status.
// Optional idle-word fill while no user data is offered: define TX_IDLE_FILL_EN.
module tx_sync_inserter #(
  parameter int DATA_WIDTH  = 24,
  parameter int SYNC_PERIOD = 64,
  parameter int SYNC_REPEAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_blocklock_local,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic                  en_wr,
  output logic [DATA_WIDTH:0]   date_wr,
  output logic                  sync_sent,
  output logic [15:0]           sync_cnt
);

  localparam int PW = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
  localparam int RW = (SYNC_REPEAT > 1) ? $clog2(SYNC_REPEAT) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SYNC_PERIOD - 1);
  localparam logic [RW-1:0] REP_LAST    = RW'(SYNC_REPEAT - 1);

  typedef enum logic {ST_DATA, ST_SYNC} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         rep_cnt_q, rep_cnt_d;
  logic [PW-1:0]         period_cnt_q, period_cnt_d;
  logic [7:0]            bl_sent_q, bl_sent_d;
  logic                  en_wr_q, en_wr_d;
  logic [DATA_WIDTH:0]   date_wr_q, date_wr_d;
  logic                  sync_sent_q, sync_sent_d;
  logic [15:0]           sync_cnt_q, sync_cnt_d;
  logic                  accept;
  logic [DATA_WIDTH:0]   sync_word;

  // Blocklock status sits zero-extended in the low bits of the payload.
  assign sync_word = {1'b1, DATA_WIDTH'(in_blocklock_local)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_SYNC;
      rep_cnt_q    <= REP_LAST;
      period_cnt_q <= '0;
      bl_sent_q    <= 8'hFF;
      en_wr_q      <= 1'b0;
      date_wr_q    <= '0;
      sync_sent_q  <= 1'b0;
      sync_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      rep_cnt_q    <= rep_cnt_d;
      period_cnt_q <= period_cnt_d;
      bl_sent_q    <= bl_sent_d;
      en_wr_q      <= en_wr_d;
      date_wr_q    <= date_wr_d;
      sync_sent_q  <= sync_sent_d;
      sync_cnt_q   <= sync_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rep_cnt_d    = rep_cnt_q;
    period_cnt_d = period_cnt_q;
    bl_sent_d    = bl_sent_q;
    en_wr_d      = 1'b0;
    date_wr_d    = date_wr_q;
    sync_sent_d  = 1'b0;
    sync_cnt_d   = sync_cnt_q;
    in_ready     = 1'b0;
    accept       = 1'b0;

    case (state_q)
      ST_DATA: begin
        in_ready = out_ready;
        accept   = in_valid && out_ready;
        if (accept) begin
          en_wr_d      = 1'b1;
          date_wr_d    = {1'b0, in_data};
          period_cnt_d = period_cnt_q + PW'(1);
        end
`ifdef TX_IDLE_FILL_EN
        else if (out_ready) begin
          en_wr_d   = 1'b1;
          date_wr_d = '0;
        end
`endif
        // A status change preempts the period; the current word still goes out first.
        if ((accept && (period_cnt_q == PERIOD_LAST)) || (in_blocklock_local != bl_sent_q)) begin
          state_d      = ST_SYNC;
          rep_cnt_d    = REP_LAST;
          period_cnt_d = '0;
        end
      end

      ST_SYNC: begin
        if (out_ready) begin
          en_wr_d     = 1'b1;
          date_wr_d   = sync_word;
          sync_sent_d = 1'b1;
          bl_sent_d   = in_blocklock_local;
          if (sync_cnt_q != 16'hFFFF) begin
            sync_cnt_d = sync_cnt_q + 16'd1;
          end
          if (rep_cnt_q == '0) begin
            state_d = ST_DATA;
          end else begin
            rep_cnt_d = rep_cnt_q - RW'(1);
          end
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  assign en_wr     = en_wr_q;
  assign date_wr   = date_wr_q;
  assign sync_sent = sync_sent_q;
  assign sync_cnt  = sync_cnt_q;

endmodule

// File: tb/tb_tx_sync_inserter.sv
// Directed bench for tx_sync_inserter: vector table for start-up and a status change,
// plus hand-written sequences for period bursts, backpressure, async reset and idle fill.
module tb_tx_sync_inserter;

`ifdef TX_IDLE_FILL_EN
  localparam bit IDLE = 1'b1;
`else
  localparam bit IDLE = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [7:0]  in_blocklock_local;
  logic        in_valid;
  logic [23:0] in_data;
  logic        in_ready;
  logic        out_ready;
  logic        en_wr;
  logic [24:0] date_wr;
  logic        sync_sent;
  logic [15:0] sync_cnt;

  int checks = 0;
  int errors = 0;

  tx_sync_inserter #(
    .DATA_WIDTH (24),
    .SYNC_PERIOD(64),
    .SYNC_REPEAT(2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_blocklock_local(in_blocklock_local),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_ready          (in_ready),
    .out_ready         (out_ready),
    .en_wr             (en_wr),
    .date_wr           (date_wr),
    .sync_sent         (sync_sent),
    .sync_cnt          (sync_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [23:0] data;
    logic        ordy;
    logic [7:0]  bl;
    logic        x_rdy;
    logic        x_en;
    logic [24:0] x_date;
    logic        x_ss;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock: drive at posedge+1, check in_ready, then check registered outputs at next posedge+1.
  task automatic step(input string tag, input logic vld, input logic [23:0] data, input logic ordy,
                      input logic [7:0] bl, input logic x_rdy, input logic x_en,
                      input logic [24:0] x_date, input logic x_ss);
    in_valid           = vld;
    in_data            = data;
    out_ready          = ordy;
    in_blocklock_local = bl;
    #1;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, {31'b0, x_rdy});
    @(posedge clk);
    #1;
    $display("txn %s en_wr=%0b date_wr=%h sync_sent=%0b", tag, en_wr, date_wr, sync_sent);
    chk({tag, "_en_wr"}, {31'b0, en_wr}, {31'b0, x_en});
    chk({tag, "_sync_sent"}, {31'b0, sync_sent}, {31'b0, x_ss});
    if (x_en) chk({tag, "_date_wr"}, {7'b0, date_wr}, {7'b0, x_date});
  endtask

  initial begin
    int          data_since;
    int          sync_left;
    logic [23:0] next_in;
    logic [23:0] exp_data;

    reset              = 1'b1;
    in_valid           = 1'b0;
    in_data            = '0;
    out_ready          = 1'b0;
    in_blocklock_local = 8'h0F;

    // Start-up burst, then data, idle, backpressure and a blocklock change (0F -> 3C).
    vecs[0]  = '{1'b0, 24'h000000, 1'b0, 8'h0F, 1'b0, 1'b0, 25'h0000000, 1'b0};
    vecs[1]  = '{1'b1, 24'hAAAAAA, 1'b1, 8'h0F, 1'b0, 1'b1, 25'h100000F, 1'b1};
    vecs[2]  = '{1'b1, 24'hAAAAAA, 1'b1, 8'h0F, 1'b0, 1'b1, 25'h100000F, 1'b1};
    vecs[3]  = '{1'b1, 24'h123456, 1'b1, 8'h0F, 1'b1, 1'b1, 25'h0123456, 1'b0};
    vecs[4]  = '{1'b0, 24'h000000, 1'b1, 8'h0F, 1'b1, IDLE, 25'h0000000, 1'b0};
    vecs[5]  = '{1'b1, 24'hFFFFFF, 1'b0, 8'h0F, 1'b0, 1'b0, 25'h0000000, 1'b0};
    vecs[6]  = '{1'b1, 24'hFFFFFF, 1'b1, 8'h0F, 1'b1, 1'b1, 25'h0FFFFFF, 1'b0};
    vecs[7]  = '{1'b1, 24'h000001, 1'b1, 8'h3C, 1'b1, 1'b1, 25'h0000001, 1'b0};
    vecs[8]  = '{1'b1, 24'h000002, 1'b1, 8'h3C, 1'b0, 1'b1, 25'h100003C, 1'b1};
    vecs[9]  = '{1'b1, 24'h000002, 1'b1, 8'h3C, 1'b0, 1'b1, 25'h100003C, 1'b1};
    vecs[10] = '{1'b1, 24'h00ABCD, 1'b1, 8'h3C, 1'b1, 1'b1, 25'h000ABCD, 1'b0};

    @(posedge clk);
    #1;
    chk("rst_en_wr", {31'b0, en_wr}, 32'd0);
    chk("rst_date_wr", {7'b0, date_wr}, 32'd0);
    chk("rst_sync_sent", {31'b0, sync_sent}, 32'd0);
    chk("rst_sync_cnt", {16'b0, sync_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      step($sformatf("vec%0d", i), vecs[i].vld, vecs[i].data, vecs[i].ordy, vecs[i].bl,
           vecs[i].x_rdy, vecs[i].x_en, vecs[i].x_date, vecs[i].x_ss);
    end
    chk("vec_sync_cnt", {16'b0, sync_cnt}, 32'd4);

    // Continuous stream: one data word already sent since the last burst; a burst follows every 64th.
    data_since = 1;
    sync_left  = 0;
    next_in    = 24'h100000;
    exp_data   = 24'h100000;
    for (int c = 0; c < 136; c++) begin
      in_valid           = 1'b1;
      in_data            = next_in;
      out_ready          = 1'b1;
      in_blocklock_local = 8'h3C;
      #1;
      chk("stream_in_ready", {31'b0, in_ready}, {31'b0, (sync_left == 0)});
      if (in_ready) next_in = next_in + 24'd1;
      @(posedge clk);
      #1;
      $display("txn stream%0d en_wr=%0b date_wr=%h sync_sent=%0b", c, en_wr, date_wr, sync_sent);
      chk("stream_en_wr", {31'b0, en_wr}, 32'd1);
      if (sync_left > 0) begin
        chk("stream_sync_word", {7'b0, date_wr}, 32'h0100003C);
        chk("stream_sync_sent", {31'b0, sync_sent}, 32'd1);
        sync_left--;
      end else begin
        chk("stream_data_word", {7'b0, date_wr}, {8'b0, exp_data});
        chk("stream_sync_sent", {31'b0, sync_sent}, 32'd0);
        exp_data = exp_data + 24'd1;
        data_since++;
        if (data_since == 64) begin
          sync_left  = 2;
          data_since = 0;
        end
      end
    end
    chk("stream_sync_cnt", {16'b0, sync_cnt}, 32'd8);

    // Blocklock change, then the pending burst is stalled by 10 clocks of backpressure.
    step("bp_trigger", 1'b0, 24'h0, 1'b1, 8'h55, 1'b1, IDLE, 25'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step($sformatf("bp_hold%0d", i), 1'b1, 24'h777777, 1'b0, 8'h55, 1'b0, 1'b0, 25'h0, 1'b0);
    end
    step("bp_sync0", 1'b1, 24'h777777, 1'b1, 8'h55, 1'b0, 1'b1, 25'h1000055, 1'b1);
    step("bp_sync1", 1'b1, 24'h777777, 1'b1, 8'h55, 1'b0, 1'b1, 25'h1000055, 1'b1);
    chk("bp_sync_cnt", {16'b0, sync_cnt}, 32'd10);
    step("bp_data", 1'b1, 24'h777777, 1'b1, 8'h55, 1'b1, 1'b1, 25'h0777777, 1'b0);

    // Asynchronous reset while a word is in the output register.
    chk("pre_rst_en_wr", {31'b0, en_wr}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_en_wr", {31'b0, en_wr}, 32'd0);
    chk("async_rst_date_wr", {7'b0, date_wr}, 32'd0);
    chk("async_rst_sync_cnt", {16'b0, sync_cnt}, 32'd0);
    chk("async_rst_sync_sent", {31'b0, sync_sent}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst_sync0", 1'b1, 24'h999999, 1'b1, 8'h55, 1'b0, 1'b1, 25'h1000055, 1'b1);
    step("post_rst_sync1", 1'b1, 24'h999999, 1'b1, 8'h55, 1'b0, 1'b1, 25'h1000055, 1'b1);
    step("post_rst_data", 1'b1, 24'h999999, 1'b1, 8'h55, 1'b1, 1'b1, 25'h0999999, 1'b0);
    chk("post_rst_sync_cnt", {16'b0, sync_cnt}, 32'd2);

    // No user data offered with room downstream.
    for (int i = 0; i < 3; i++) begin
      step($sformatf("idle%0d", i), 1'b0, 24'h0, 1'b1, 8'h55, 1'b1, IDLE, 25'h0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
